// File: rtl/ddr_arb_pkg.sv
// ddr_arb_pkg: shared state encoding, default sizing and width helper for the DDR port arbiter.
package ddr_arb_pkg;
  localparam int N_WR_DEFAULT = 2;
  localparam int READER_ID = N_WR_DEFAULT;
  typedef enum logic [2:0] {IDLE, AW, WD, AR, RD} arb_state_t;
  function automatic int cnt_w(input int max_val);
    return max_val < 2 ? 1 : $clog2(max_val + 1);
  endfunction
endpackage

// File: rtl/ddr_port_arbiter_rr_select.sv
// rr_select: round-robin picker searching upward from ptr; requests also set in ovr win outright.
module rr_select
  import ddr_arb_pkg::*;
#(
  parameter int N  = 3,
  parameter int IW = cnt_w(N - 1)
) (
  input  logic [N-1:0]  req,
  input  logic [N-1:0]  ovr,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);
  logic [N-1:0] cand;
  assign cand = |(req & ovr) ? req & ovr : req;
  assign any = |req;
  assign gnt = any ? N'(1) << idx : '0;
  always_comb begin
    idx = '0;
    for (int k = N - 1; k >= 0; k--)
      if (cand[IW'((int'(ptr) + k) % N)]) idx = IW'((int'(ptr) + k) % N);
  end
endmodule

// File: rtl/ddr_port_arbiter.sv
// ddr_port_arbiter: shares one AXI-style ddr3_32 port between N_WR burst writers and one reader.
module ddr_port_arbiter
  import ddr_arb_pkg::*;
#(
  parameter int N_WR    = N_WR_DEFAULT,
  parameter int ADDR_W  = 28,
  parameter int LEN_W   = 4,
  parameter int DATA_W  = 256,
  parameter int TIMEOUT = 1023
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_WR-1:0]          wr_req,
  input  logic [N_WR*ADDR_W-1:0]   wr_addr,
  input  logic [N_WR*LEN_W-1:0]    wr_len,
  output logic [N_WR-1:0]          wr_gnt,
  input  logic [N_WR*DATA_W-1:0]   wr_data,
  output logic [N_WR-1:0]          wr_data_rdy,
  output logic [N_WR-1:0]          wr_done,
  input  logic                     rd_req,
  input  logic                     rd_urgent,
  input  logic [ADDR_W-1:0]        rd_addr,
  input  logic [LEN_W-1:0]         rd_len,
  output logic                     rd_gnt,
  output logic                     rd_valid,
  output logic [DATA_W-1:0]        rd_data,
  output logic                     rd_last,
  output logic [ADDR_W-1:0]        axi_awaddr,
  output logic                     axi_awuser_ap,
  output logic [3:0]               axi_awuser_id,
  output logic [LEN_W-1:0]         axi_awlen,
  output logic                     axi_awvalid,
  input  logic                     axi_awready,
  output logic [DATA_W-1:0]        axi_wdata,
  output logic [DATA_W/8-1:0]      axi_wstrb,
  input  logic                     axi_wready,
  input  logic [3:0]               axi_wusero_id,
  input  logic                     axi_wusero_last,
  output logic [ADDR_W-1:0]        axi_araddr,
  output logic                     axi_aruser_ap,
  output logic [3:0]               axi_aruser_id,
  output logic [LEN_W-1:0]         axi_arlen,
  output logic                     axi_arvalid,
  input  logic                     axi_arready,
  input  logic [DATA_W-1:0]        axi_rdata,
  input  logic [3:0]               axi_rid,
  input  logic                     axi_rlast,
  input  logic                     axi_rvalid,
  output logic                     busy,
  output logic                     err
);
  localparam int SW = cnt_w(N_WR);
  localparam int WW = cnt_w(N_WR - 1);
  localparam int TW = cnt_w(TIMEOUT);
  arb_state_t state;
  logic [SW-1:0] ptr, sel, win;
  logic [N_WR:0] pick;
  logic any, wlast, tmo, unused_wid;
  logic [LEN_W-1:0] len, beat;
  logic [TW-1:0] tcnt;
  logic [ADDR_W-1:0] addr;
  logic [WW-1:0] ws;
  rr_select #(.N(N_WR + 1), .IW(SW)) u_rr (
    .req({rd_req, wr_req}),
    .ovr({rd_urgent, {N_WR{1'b0}}}),
    .ptr(ptr),
    .gnt(pick),
    .idx(win),
    .any(any)
  );
  assign unused_wid = ^axi_wusero_id;
  assign ws = sel[WW-1:0];
  assign tmo = tcnt == TW'(TIMEOUT - 1);
  assign wlast = (axi_wready && beat == len) || axi_wusero_last;
  assign busy = state != IDLE;
  assign axi_awaddr = addr;
  assign axi_araddr = addr;
  assign axi_awlen = len;
  assign axi_arlen = len;
  assign axi_awuser_id = 4'(sel);
  assign axi_aruser_id = 4'(N_WR);
  assign axi_awuser_ap = 1'b1;
  assign axi_aruser_ap = 1'b1;
  assign axi_wstrb = '1;
  assign axi_wdata = wr_data[ws*DATA_W +: DATA_W];
  assign wr_data_rdy = state == WD ? N_WR'(axi_wready) << ws : '0;
  assign rd_valid = state == RD && axi_rvalid;
  assign rd_last = state == RD && axi_rlast;
  assign rd_data = state == RD ? axi_rdata : '0;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ptr <= '0;
      sel <= '0;
      len <= '0;
      beat <= '0;
      tcnt <= '0;
      addr <= '0;
      wr_gnt <= '0;
      rd_gnt <= 1'b0;
      wr_done <= '0;
      axi_awvalid <= 1'b0;
      axi_arvalid <= 1'b0;
      err <= 1'b0;
    end else begin
      wr_gnt <= '0;
      rd_gnt <= 1'b0;
      wr_done <= '0;
      tcnt <= tcnt + 1'b1;
      if (state == IDLE) begin
        if (any) begin
          ptr <= win == SW'(N_WR) ? '0 : win + 1'b1;
          sel <= win;
          tcnt <= '0;
          beat <= '0;
          wr_gnt <= pick[N_WR-1:0];
          rd_gnt <= pick[N_WR];
          addr <= pick[N_WR] ? rd_addr : wr_addr[win[WW-1:0]*ADDR_W +: ADDR_W];
          len <= pick[N_WR] ? rd_len : wr_len[win[WW-1:0]*LEN_W +: LEN_W];
          axi_awvalid <= !pick[N_WR];
          axi_arvalid <= pick[N_WR];
          state <= pick[N_WR] ? AR : AW;
        end
      end else if ((state == AW && axi_awready) || (state == AR && axi_arready)) begin
        axi_awvalid <= 1'b0;
        axi_arvalid <= 1'b0;
        tcnt <= '0;
        state <= state == AW ? WD : RD;
      end else if (state == WD && (axi_wready || axi_wusero_last)) begin
        beat <= beat + LEN_W'(axi_wready);
        tcnt <= '0;
        if (wlast) begin
          wr_done <= N_WR'(1) << ws;
          state <= IDLE;
        end
      end else if (state == RD && axi_rvalid) begin
        tcnt <= '0;
        if (axi_rid != 4'(N_WR)) err <= 1'b1;
        if (axi_rlast) state <= IDLE;
      end else if (tmo) begin
        err <= 1'b1;
        axi_awvalid <= 1'b0;
        axi_arvalid <= 1'b0;
        state <= IDLE;
      end
    end
  end
endmodule

// File: tb/tb_ddr_port_arbiter.sv
// tb_ddr_port_arbiter: transaction-level model checked every cycle, directed scenarios plus random traffic.
module tb_ddr_port_arbiter;
  localparam int NW = 2, DW = 32, TO = 16;
  logic clk = 1'b0, rst = 1'b1;
  logic [NW-1:0] wr_req, wr_gnt, wr_data_rdy, wr_done;
  logic [NW*28-1:0] wr_addr;
  logic [NW*4-1:0] wr_len;
  logic [NW*DW-1:0] wr_data;
  logic rd_req, rd_urgent, rd_gnt, rd_valid, rd_last;
  logic [27:0] rd_addr, axi_awaddr, axi_araddr;
  logic [3:0] rd_len, axi_awlen, axi_arlen, axi_awuser_id, axi_aruser_id, axi_wusero_id, axi_rid;
  logic [DW-1:0] rd_data, axi_wdata, axi_rdata;
  logic [DW/8-1:0] axi_wstrb;
  logic axi_awuser_ap, axi_aruser_ap, axi_awvalid, axi_awready, axi_wready, axi_wusero_last;
  logic axi_arvalid, axi_arready, axi_rlast, axi_rvalid, busy, err;
  int vectors = 0, errors = 0, cyc = 0;
  bit go = 0, auto_mode = 0;
  int m_phase = 0, m_who = 0, m_ptr = 0, m_wait = 0, m_left = 0, m_rbeats = 0;
  bit m_rd = 0, m_err = 0, m_rgnt = 0;
  logic [NW-1:0] m_wgnt = '0, m_done = '0, m_cons = '0;
  logic [27:0] m_addr = '0;
  logic [3:0] m_len = '0;

  always #5 clk = ~clk;

  ddr_port_arbiter #(.N_WR(NW), .ADDR_W(28), .LEN_W(4), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .wr_req(wr_req), .wr_addr(wr_addr), .wr_len(wr_len), .wr_gnt(wr_gnt),
    .wr_data(wr_data), .wr_data_rdy(wr_data_rdy), .wr_done(wr_done), .rd_req(rd_req),
    .rd_urgent(rd_urgent), .rd_addr(rd_addr), .rd_len(rd_len), .rd_gnt(rd_gnt), .rd_valid(rd_valid),
    .rd_data(rd_data), .rd_last(rd_last), .axi_awaddr(axi_awaddr), .axi_awuser_ap(axi_awuser_ap),
    .axi_awuser_id(axi_awuser_id), .axi_awlen(axi_awlen), .axi_awvalid(axi_awvalid),
    .axi_awready(axi_awready), .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wready(axi_wready),
    .axi_wusero_id(axi_wusero_id), .axi_wusero_last(axi_wusero_last), .axi_araddr(axi_araddr),
    .axi_aruser_ap(axi_aruser_ap), .axi_aruser_id(axi_aruser_id), .axi_arlen(axi_arlen),
    .axi_arvalid(axi_arvalid), .axi_arready(axi_arready), .axi_rdata(axi_rdata), .axi_rid(axi_rid),
    .axi_rlast(axi_rlast), .axi_rvalid(axi_rvalid), .busy(busy), .err(err)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Burst-level view: idle / address phase / data phase, with a stall counter per phase.
  task automatic model_step();
    int win;
    bit prog;
    m_wgnt = '0; m_rgnt = 0; m_done = '0; m_cons = '0;
    if (rst) begin
      m_phase = 0; m_who = 0; m_ptr = 0; m_err = 0; m_addr = '0; m_len = '0; m_rd = 0;
    end else if (m_phase == 0) begin
      win = -1;
      if (rd_req && rd_urgent) win = NW;
      else
        for (int k = 0; k <= NW; k++) begin
          int s;
          s = (m_ptr + k) % (NW + 1);
          if (win < 0 && (s == NW ? rd_req : wr_req[s])) win = s;
        end
      if (win >= 0) begin
        m_who = win; m_ptr = (win + 1) % (NW + 1); m_phase = 1; m_wait = 0; m_rbeats = 0;
        m_rd = win == NW;
        if (m_rd) begin
          m_rgnt = 1; m_addr = rd_addr; m_len = rd_len;
        end else begin
          m_wgnt[win] = 1'b1; m_addr = wr_addr[win*28 +: 28]; m_len = wr_len[win*4 +: 4];
          m_left = int'(m_len) + 1;
        end
      end
    end else begin
      prog = m_phase == 1 ? (m_rd ? axi_arready : axi_awready)
                          : (m_rd ? axi_rvalid : (axi_wready || axi_wusero_last));
      if (!prog) begin
        m_wait++;
        if (m_wait == TO) begin m_err = 1; m_phase = 0; end
      end else begin
        m_wait = 0;
        if (m_phase == 1) m_phase = 2;
        else if (m_rd) begin
          m_rbeats++;
          if (axi_rid != 4'd2) m_err = 1;
          if (axi_rlast) m_phase = 0;
        end else begin
          if (axi_wready) begin m_left--; m_cons[m_who] = 1'b1; end
          if (m_left == 0 || axi_wusero_last) begin m_done[m_who] = 1'b1; m_phase = 0; end
        end
      end
    end
  endtask

  task automatic drive_random();
    bit stall, rdp;
    for (int i = 0; i < NW; i++) begin
      if (m_wgnt[i]) wr_req[i] = 1'b0;
      else if (!wr_req[i] && $urandom_range(7) == 0) begin
        wr_req[i] = 1'b1; wr_addr[i*28 +: 28] = 28'($urandom); wr_len[i*4 +: 4] = 4'($urandom_range(3));
      end
      if (m_cons[i]) wr_data[i*DW +: DW] = $urandom;
    end
    if (m_rgnt) begin rd_req = 1'b0; rd_urgent = 1'b0; end
    else if (!rd_req && $urandom_range(5) == 0) begin
      rd_req = 1'b1; rd_addr = 28'($urandom); rd_len = 4'($urandom_range(7));
    end
    if (rd_req) rd_urgent = $urandom_range(3) == 0;
    stall = (cyc / 150) % 6 == 5;
    rdp = m_phase == 2 && m_rd;
    axi_awready = !stall && $urandom_range(1) == 1;
    axi_arready = !stall && $urandom_range(1) == 1;
    axi_wready = !stall && $urandom_range(1) == 1;
    axi_wusero_last = $urandom_range(63) == 0;
    axi_wusero_id = 4'($urandom);
    axi_rvalid = (rdp ? !stall : 1'b1) && $urandom_range(1) == 1;
    axi_rlast = rdp ? (m_rbeats == int'(m_len)) : ($urandom_range(1) == 1);
    axi_rdata = $urandom;
    axi_rid = $urandom_range(99) == 0 ? 4'($urandom) : 4'd2;
    rst = $urandom_range(299) == 0;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    go = 1;
    #1;
    cyc++;
    if (auto_mode) drive_random();
  endtask

  always @(negedge clk) if (go) begin
    chk("busy", 64'(busy), 64'(m_phase != 0));
    chk("err", 64'(err), 64'(m_err));
    chk("wr_gnt", 64'(wr_gnt), 64'(m_wgnt));
    chk("rd_gnt", 64'(rd_gnt), 64'(m_rgnt));
    chk("wr_done", 64'(wr_done), 64'(m_done));
    chk("awvalid", 64'(axi_awvalid), 64'(m_phase == 1 && !m_rd));
    chk("arvalid", 64'(axi_arvalid), 64'(m_phase == 1 && m_rd));
    if (m_phase == 1 && !m_rd) begin
      chk("awaddr", 64'(axi_awaddr), 64'(m_addr));
      chk("awlen", 64'(axi_awlen), 64'(m_len));
      chk("awuser_id", 64'(axi_awuser_id), 64'(m_who));
    end
    if (m_phase == 1 && m_rd) begin
      chk("araddr", 64'(axi_araddr), 64'(m_addr));
      chk("arlen", 64'(axi_arlen), 64'(m_len));
    end
    chk("wr_data_rdy", 64'(wr_data_rdy), (m_phase == 2 && !m_rd && axi_wready) ? 64'(1) << m_who : 64'(0));
    if (m_phase == 2 && !m_rd) chk("wdata", 64'(axi_wdata), 64'(wr_data[m_who*DW +: DW]));
    chk("rd_valid", 64'(rd_valid), 64'(m_phase == 2 && m_rd && axi_rvalid));
    chk("rd_last", 64'(rd_last), 64'(m_phase == 2 && m_rd && axi_rlast));
    if (m_phase == 2 && m_rd) chk("rd_data", 64'(rd_data), 64'(axi_rdata));
    chk("consts", 64'({axi_wstrb, axi_awuser_ap, axi_aruser_ap, axi_aruser_id}), 64'({4'hf, 1'b1, 1'b1, 4'd2}));
  end

  initial begin
    int k, cnt;
    int log_q[$];
    int exp_ord[4] = '{0, 1, 2, 0};
    logic [7:0] rv, dv;
    {wr_req, rd_req, rd_urgent, axi_awready, axi_wready, axi_arready} = '0;
    {axi_rvalid, axi_rlast, axi_wusero_last} = '0;
    wr_addr = '0; wr_len = '0; rd_addr = 28'h0abcde0; rd_len = '0;
    wr_data = {$urandom, $urandom}; axi_rdata = '0; axi_rid = 4'd2; axi_wusero_id = '0;
    rst = 1'b1; tick(); tick(); rst = 1'b0;
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_err", 64'(err), 64'(0));
    chk("rst_gnt", 64'({rd_gnt, wr_gnt}), 64'(0));
    chk("rst_valids", 64'({axi_awvalid, axi_arvalid}), 64'(0));
    // single write len=3, awready after two waiting cycles
    wr_addr[27:0] = 28'h1234560; wr_len[3:0] = 4'd3; wr_req = 2'b01; axi_wready = 1'b1;
    tick(); chk("w1_gnt", 64'(wr_gnt), 64'(2'b01)); wr_req = '0;
    tick(); chk("w1_awaddr", 64'(axi_awaddr), 64'(28'h1234560)); axi_awready = 1'b1;
    rv = '0; dv = '0;
    for (int i = 0; i < 8; i++) begin tick(); rv[i] = wr_data_rdy[0]; dv[i] = wr_done[0]; end
    chk("w1_rdy_pattern", 64'(rv), 64'(8'h0f));
    chk("w1_done_pattern", 64'(dv), 64'(8'h10));
    // everyone requesting continuously from pointer 0
    rst = 1'b1; tick(); rst = 1'b0;
    wr_len = {4'd1, 4'd1}; rd_len = '0; wr_req = 2'b11; rd_req = 1'b1;
    {axi_awready, axi_arready, axi_wready, axi_rvalid, axi_rlast} = '1;
    for (int i = 0; i < 60 && log_q.size() < 4; i++) begin
      tick();
      if (wr_gnt[0]) log_q.push_back(0);
      if (wr_gnt[1]) log_q.push_back(1);
      if (rd_gnt) log_q.push_back(2);
    end
    chk("order_count", 64'(log_q.size()), 64'(4));
    for (int i = 0; i < 4; i++) chk("order", 64'(i < log_q.size() ? log_q[i] : -1), 64'(exp_ord[i]));
    // urgent read wins over both writers
    rst = 1'b1; tick(); rst = 1'b0;
    wr_req = 2'b11; rd_req = 1'b1; rd_urgent = 1'b1; rd_len = 4'd7;
    {axi_awready, axi_rvalid, axi_rlast} = '0; axi_arready = 1'b1;
    tick();
    chk("urg_rd_gnt", 64'(rd_gnt), 64'(1));
    chk("urg_wr_gnt", 64'(wr_gnt), 64'(0));
    rd_req = 1'b0; rd_urgent = 1'b0; cnt = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      axi_rvalid = cnt < 8; axi_rdata = $urandom; axi_rlast = cnt == 7;
      #1;
      if (rd_valid) begin
        chk("urg_data", 64'(rd_data), 64'(axi_rdata));
        chk("urg_last", 64'(rd_last), 64'(cnt == 7));
        cnt++;
      end
    end
    chk("urg_beats", 64'(cnt), 64'(8));
    wr_req = '0; axi_rvalid = 1'b0; axi_rlast = 1'b0;
    // arready stuck low until the timeout abort
    rst = 1'b1; tick(); rst = 1'b0;
    rd_req = 1'b1; rd_len = '0; axi_arready = 1'b0;
    tick(); rd_req = 1'b0; k = 0;
    for (int i = 1; i <= 40 && k == 0; i++) begin tick(); if (err) k = i; end
    chk("to_cycle", 64'(k), 64'(16));
    chk("to_arvalid", 64'(axi_arvalid), 64'(0));
    chk("to_busy", 64'(busy), 64'(0));
    rd_req = 1'b1; axi_arready = 1'b1;
    tick(); chk("to_regrant", 64'(rd_gnt), 64'(1)); rd_req = 1'b0;
    tick(); axi_rvalid = 1'b1; axi_rlast = 1'b1;
    tick(); axi_rvalid = 1'b0; axi_rlast = 1'b0;
    // reset in the middle of a write data phase
    rst = 1'b1; tick(); rst = 1'b0;
    wr_len = {4'd7, 4'd0}; wr_req = 2'b10; axi_awready = 1'b1; axi_wready = 1'b1;
    tick(); wr_req = '0; tick(); tick();
    chk("mid_busy", 64'(busy), 64'(1));
    rst = 1'b1; tick(); rst = 1'b0;
    chk("abort_busy", 64'(busy), 64'(0));
    chk("abort_rdy", 64'(wr_data_rdy), 64'(0));
    chk("abort_valids", 64'({axi_awvalid, axi_arvalid, rd_valid}), 64'(0));
    chk("abort_done", 64'(wr_done), 64'(0));
    chk("abort_err", 64'(err), 64'(0));
    auto_mode = 1;
    repeat (4000) tick();
    auto_mode = 0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
